// File: rtl/lector_contador.sv
// Requester for the FIFO pop-count readback: waits for IDLE, reads every FIFO
// count plus the total, then checks that the per-FIFO counts add up to the total.
module lector_contador #(
    parameter int FIFO_UNITS = 4,
    parameter int INDEX      = 2,
    parameter int TIMEOUT    = 15,
    parameter int TO_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             IDLE,
    input  logic             valid,
    input  logic [4:0]       cuenta,
    input  logic [4:0]       contador_4,
    output logic             req,
    output logic [INDEX-1:0] idx,
    output logic [4:0]       conteo_0,
    output logic [4:0]       conteo_1,
    output logic [4:0]       conteo_2,
    output logic [4:0]       conteo_3,
    output logic [4:0]       total,
    output logic [6:0]       suma,
    output logic             done,
    output logic             error,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ESPERA,
        SOLICITUD,
        COMPARA,
        FIN
    } state_t;

    state_t           state, state_next;
    logic             pending;
    logic [INDEX-1:0] ptr;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_inc;
    logic [4:0]       conteo [FIFO_UNITS];
    logic [6:0]       sum_all;

    logic launch;
    logic capture;
    logic expire;
    logic compare;
    logic last_idx;

    assign idx        = ptr;
    assign conteo_0   = conteo[0];
    assign conteo_1   = conteo[1];
    assign conteo_2   = conteo[2];
    assign conteo_3   = conteo[3];
    assign to_cnt_inc = to_cnt + TO_W'(1);
    assign last_idx   = (ptr == INDEX'(FIFO_UNITS - 1));

    always_comb begin
        sum_all = '0;
        for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
            sum_all = sum_all + 7'(conteo[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ESPERA;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        compare    = 1'b0;
        case (state)
            ESPERA: begin
                if (pending && IDLE) begin
                    launch     = 1'b1;
                    state_next = SOLICITUD;
                end
            end
            SOLICITUD: begin
                // Responder is combinational, so valid answers the req/idx driven this cycle.
                if (valid) begin
                    capture = 1'b1;
                    if (last_idx) begin
                        state_next = COMPARA;
                    end
                end else if (to_cnt_inc == TO_W'(TIMEOUT)) begin
                    expire     = 1'b1;
                    state_next = FIN;
                end
            end
            COMPARA: begin
                compare    = 1'b1;
                state_next = FIN;
            end
            FIN: begin
                state_next = ESPERA;
            end
            default: begin
                state_next = ESPERA;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            req     <= 1'b0;
            done    <= 1'b0;
            pending <= 1'b0;
            ptr     <= '0;
            to_cnt  <= '0;
            total   <= '0;
            suma    <= '0;
            error   <= 1'b0;
            timeout <= 1'b0;
            for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
                conteo[i] <= '0;
            end
        end else begin
            // req and done are registered copies of the state being entered.
            req  <= (state_next == SOLICITUD);
            done <= (state_next == FIN);

            if (launch) begin
                pending <= 1'b0;
            end else if (state == ESPERA && start) begin
                pending <= 1'b1;
            end

            if (launch) begin
                ptr     <= '0;
                to_cnt  <= '0;
                total   <= '0;
                suma    <= '0;
                error   <= 1'b0;
                timeout <= 1'b0;
                for (int unsigned i = 0; i < FIFO_UNITS; i++) begin
                    conteo[i] <= '0;
                end
            end

            if (capture) begin
                conteo[ptr] <= cuenta;
                total       <= contador_4;
                to_cnt      <= '0;
                if (!last_idx) begin
                    ptr <= ptr + INDEX'(1);
                end
            end else if (state == SOLICITUD) begin
                to_cnt <= to_cnt_inc;
            end

            if (expire) begin
                timeout <= 1'b1;
            end

            // Responder counters are 5 bits and wrap, so compare modulo 32.
            if (compare) begin
                suma  <= sum_all;
                error <= (sum_all[4:0] != total);
            end
        end
    end

endmodule

// File: tb/tb_lector_contador.sv
// Self-checking bench for lector_contador: a combinational responder model plus
// directed and randomized readbacks compared against arithmetic expectations.
module tb_lector_contador;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       IDLE;
    logic       valid;
    logic [4:0] cuenta;
    logic [4:0] contador_4;
    logic       req;
    logic [1:0] idx;
    logic [4:0] conteo_0, conteo_1, conteo_2, conteo_3;
    logic [4:0] total;
    logic [6:0] suma;
    logic       done;
    logic       error;
    logic       timeout;

    logic [4:0] c_tab [4];
    logic [4:0] tot_val;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // Responder: answers only while the output stage is idle.
    assign valid      = req && IDLE;
    assign cuenta     = c_tab[idx];
    assign contador_4 = tot_val;

    lector_contador #(
        .FIFO_UNITS(4),
        .INDEX(2),
        .TIMEOUT(TIMEOUT),
        .TO_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .IDLE(IDLE),
        .valid(valid),
        .cuenta(cuenta),
        .contador_4(contador_4),
        .req(req),
        .idx(idx),
        .conteo_0(conteo_0),
        .conteo_1(conteo_1),
        .conteo_2(conteo_2),
        .conteo_3(conteo_3),
        .total(total),
        .suma(suma),
        .done(done),
        .error(error),
        .timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // drop_at: index at which IDLE falls (4 = never); idle_delay: cycles IDLE stays low after start.
    task automatic run(input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2,
                       input logic [4:0] c3, input logic [4:0] tv, input int drop_at,
                       input int idle_delay);
        int e, first_req, done_edge, k, sum, launch, exp_done;
        bit to_exp;
        int seq[$];
        logic [4:0] cv [4];
        logic [31:0] conteo_obs [4];

        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
        @(negedge clk);
        c_tab[0] = c0; c_tab[1] = c1; c_tab[2] = c2; c_tab[3] = c3;
        tot_val = tv;
        IDLE    = (idle_delay == 0);
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start     = 1'b0;
        e         = 0;
        first_req = -1;
        done_edge = -1;
        for (int it = 0; it < 200 && done_edge < 0; it++) begin
            if (idle_delay > 0 && e == idle_delay) IDLE = 1'b1;
            if (req && int'(idx) == drop_at) IDLE = 1'b0;
            @(posedge clk);
            e++;
            @(negedge clk);
            if (req && first_req < 0) first_req = e;
            if (req && (seq.size() == 0 || seq[$] != int'(idx))) seq.push_back(int'(idx));
            if (done) done_edge = e;
        end

        sum      = int'(c0) + int'(c1) + int'(c2) + int'(c3);
        to_exp   = (drop_at < 4);
        k        = to_exp ? drop_at : 4;
        launch   = idle_delay + 1;
        exp_done = launch + k + (to_exp ? TIMEOUT : 1);

        check("first_req_edge", first_req, launch);
        check("done_edge", done_edge, exp_done);
        check("idx_seq_len", seq.size(), to_exp ? k + 1 : 4);
        for (int i = 0; i < seq.size() && i < 4; i++) check("idx_order", seq[i], i);

        conteo_obs[0] = 32'(conteo_0);
        conteo_obs[1] = 32'(conteo_1);
        conteo_obs[2] = 32'(conteo_2);
        conteo_obs[3] = 32'(conteo_3);
        for (int i = 0; i < 4; i++) check("conteo", conteo_obs[i], (i < k) ? 32'(cv[i]) : 0);
        check("total", total, (k > 0) ? 32'(tv) : 0);
        check("suma", suma, to_exp ? 0 : sum);
        check("error", error, to_exp ? 0 : ((sum % 32) != int'(tv)));
        check("timeout", timeout, to_exp);
        check("req_at_done", req, 0);
        @(negedge clk);
        check("done_width", done, 0);
    endtask

    initial begin
        int guard;
        logic [4:0] r0, r1, r2, r3, rt;
        int s;

        reset = 1'b0;
        start = 1'b0;
        IDLE  = 1'b0;
        tot_val = '0;
        for (int i = 0; i < 4; i++) c_tab[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {req, idx, done, error, timeout}, 0);
        check("reset_data", {conteo_0, conteo_1, conteo_2, conteo_3, total, suma}, 0);
        reset = 1'b1;

        run(5'd3, 5'd5, 5'd0, 5'd7, 5'd15, 4, 0);
        run(5'd3, 5'd5, 5'd0, 5'd7, 5'd14, 4, 0);
        run(5'd31, 5'd1, 5'd0, 5'd0, 5'd0, 4, 0);
        run(5'd4, 5'd6, 5'd9, 5'd2, 5'd21, 2, 0);
        run(5'd1, 5'd2, 5'd3, 5'd4, 5'd10, 4, 10);

        // Reset while requesting idx 2.
        @(negedge clk);
        c_tab[0] = 5'd9; c_tab[1] = 5'd8; c_tab[2] = 5'd7; c_tab[3] = 5'd6;
        tot_val = 5'd30;
        IDLE    = 1'b1;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(req && idx == 2'd2) && guard < 50) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        check("reach_idx2", guard < 50, 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_ctrl", {req, idx, done, error, timeout}, 0);
        check("midreset_data", {conteo_0, conteo_1, conteo_2, conteo_3, total, suma}, 0);
        reset = 1'b1;
        run(5'd2, 5'd2, 5'd2, 5'd2, 5'd8, 4, 0);

        for (int n = 0; n < 10; n++) begin
            r0 = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom); r3 = 5'($urandom);
            s  = int'(r0) + int'(r1) + int'(r2) + int'(r3);
            rt = ($urandom_range(0, 1) == 1) ? 5'(s) : 5'($urandom);
            run(r0, r1, r2, r3, rt,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4,
                int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/lector_contador.md
Name: lector_contador

Overview:
- Requester side of the count-readback interface served by the FIFO pop-counter block (req/idx in; cuenta/contador_4/valid out).
- After the output stage reports all FIFOs empty (IDLE=1), it reads the pop count of every output FIFO in turn and captures the total-pop count.
- It then checks that the per-FIFO counts sum to the total and presents the results to the test/control layer.

Parameters:
- FIFO_UNITS, 4, number of output FIFOs to read (indices 0..FIFO_UNITS-1).
- INDEX, 2, idx width, equal to log2(FIFO_UNITS).
- TIMEOUT, 15, maximum cycles to wait for valid on one index.
- TO_W, 4, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to perform a readback.
- IDLE  in  1  all output FIFOs empty.
- valid  in  1  responder's cuenta/contador_4 are valid in this cycle.
- cuenta  in  5  pop count of FIFO idx.
- contador_4  in  5  total pop count.
- req  out  1  readback request to the responder.
- idx  out  INDEX  FIFO index being requested.
- conteo_0..conteo_3  out  5 each  captured per-FIFO counts.
- total  out  5  captured contador_4.
- suma  out  7  full-width sum of conteo_0..3.
- done  out  1  one-cycle pulse when a readback finishes.
- error  out  1  sum mismatch flag.
- timeout  out  1  readback aborted flag.

Behaviour:
- Reset: on clk edge with reset=0, all of the following clear to 0: outputs, FSM (returns to ESPERA), pending flag, pointer, timeout counter. Reset is honoured mid-readback, and any partial captures are discarded.
- start handling:
  - start seen in ESPERA sets a pending flag.
  - start seen in any other state is ignored.
- State ESPERA:
  - req=0.
  - When pending=1 and IDLE=1: clear conteo_*, total, suma, error and timeout; set pointer to 0; clear pending; go to SOLICITUD next cycle.
  - If IDLE=0 the pending flag is held indefinitely.
- State SOLICITUD:
  - Drives req=1, idx=pointer (registered outputs).
  - valid is sampled in the same cycle, because the responder is combinational.
  - On valid=1: capture cuenta into conteo_[pointer], capture contador_4 into total, reset the timeout counter.
    - If pointer = FIFO_UNITS-1, go to COMPARA.
    - Otherwise increment pointer and stay.
  - On valid=0: increment the timeout counter. When it reaches TIMEOUT: set timeout=1, req=0, go to FIN.
  - If IDLE drops mid-readback, the responder drops valid and the timeout path handles it. Counts already captured are kept; the rest stay 0.
- State COMPARA:
  - req=0.
  - suma = zero-extended sum of the four conteo values (7 bits, no overflow).
  - error = (suma[4:0] != total). The comparison is modulo 32, because the responder's 5-bit counters wrap.
  - Go to FIN.
- State FIN:
  - done=1 for exactly one cycle, then go to ESPERA.
  - conteo_*, total, suma, error and timeout hold until the next accepted readback or reset.
- Latency: start and IDLE high at edge 0, responder always valid. Then:
  - req asserts after edge 1.
  - Indices 0..3 are sampled at edges 2..5.
  - COMPARA runs in the cycle after edge 5.
  - done is high in the cycle after edge 6.
  - Total: 7 cycles from start to done.
- Timeout and error are mutually exclusive: error is evaluated only in COMPARA.

Test Plan:
- Normal readback: counts 3,5,0,7, contador_4=15, start with IDLE=1 -> req high with idx 0,1,2,3 on consecutive cycles; done pulses 7 cycles after start; suma=15, error=0, timeout=0.
- Mismatch: counts 3,5,0,7, contador_4=14 -> done pulses; suma=15, error=1.
- Wrap-around: counts 31,1,0,0, contador_4=0 -> suma=32, suma[4:0]=0, error=0.
- IDLE drops after idx 1 is captured -> after 15 cycles of valid=0: timeout=1, done pulses, conteo_2=conteo_3=0, error=0, req=0.
- start while IDLE=0, IDLE rises 10 cycles later -> no req before IDLE=1; readback then runs with the normal 7-cycle latency measured from IDLE rising.
- reset=0 asserted during SOLICITUD at idx 2 -> next cycle all outputs 0, FSM in ESPERA; a new start completes a normal readback.
